// File: rtl/wb_write_queue.sv
// wb_write_queue: in-order writeback buffer in front of the register file
// write port, with two bypass lookup ports over the pending entries.
module wb_write_queue #(
  parameter int BITWIDTH = 16,
  parameter int DEPTH    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                memValid,
  input  logic [2:0]          memRegSel,
  input  logic [BITWIDTH-1:0] memData,
  input  logic                aluValid,
  input  logic [2:0]          aluRegSel,
  input  logic [BITWIDTH-1:0] aluData,
  output logic                stall,
  output logic                writeEn,
  output logic [2:0]          writeRegSel,
  output logic [BITWIDTH-1:0] writeData,
  input  logic [2:0]          lookup1RegSel,
  output logic                lookup1Hit,
  output logic [BITWIDTH-1:0] lookup1Data,
  input  logic [2:0]          lookup2RegSel,
  output logic                lookup2Hit,
  output logic [BITWIDTH-1:0] lookup2Data,
  output logic                err
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  logic [2:0]          rsel_q [DEPTH];
  logic [BITWIDTH-1:0] data_q [DEPTH];

  ptr_t head;
  ptr_t tail;
  ptr_t tail_alu;
  cnt_t count;
  cnt_t free;
  logic pop;
  logic push_mem;
  logic push_alu;

  assign pop   = (count != '0);
  assign free  = cnt_t'(DEPTH) - count + cnt_t'(pop);
  assign stall = (free < cnt_t'(2));

  // a stalled cycle drops both pushes together
  assign push_mem = memValid & ~stall;
  assign push_alu = aluValid & ~stall;
  assign tail_alu = tail + ptr_t'(push_mem);

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      err   <= 1'b0;
    end else begin
      head  <= head + ptr_t'(pop);
      tail  <= tail + ptr_t'(push_mem)
                    + ptr_t'(push_alu);
      count <= count + cnt_t'(push_mem)
                     + cnt_t'(push_alu)
                     - cnt_t'(pop);
      if (stall && (memValid || aluValid))
        err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_mem) begin
      rsel_q[tail] <= memRegSel;
      data_q[tail] <= memData;
    end
    if (push_alu) begin
      rsel_q[tail_alu] <= aluRegSel;
      data_q[tail_alu] <= aluData;
    end
  end

  assign writeEn     = pop;
  assign writeRegSel = pop ? rsel_q[head] : '0;
  assign writeData   = pop ? data_q[head] : '0;

  // scan oldest to youngest so the youngest match wins
  always_comb begin
    lookup1Hit  = 1'b0;
    lookup1Data = '0;
    lookup2Hit  = 1'b0;
    lookup2Data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (cnt_t'(i) < count) begin
        if (rsel_q[head + ptr_t'(i)] == lookup1RegSel) begin
          lookup1Hit  = 1'b1;
          lookup1Data = data_q[head + ptr_t'(i)];
        end
        if (rsel_q[head + ptr_t'(i)] == lookup2RegSel) begin
          lookup2Hit  = 1'b1;
          lookup2Data = data_q[head + ptr_t'(i)];
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_write_queue.sv
// tb_wb_write_queue: scoreboard bench for wb_write_queue.
// Expected writes are queued at push time and matched as the DUT drains.
module tb_wb_write_queue;

  localparam int BW = 16;
  localparam int DP = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          memValid;
  logic [2:0]    memRegSel;
  logic [BW-1:0] memData;
  logic          aluValid;
  logic [2:0]    aluRegSel;
  logic [BW-1:0] aluData;
  logic          stall;
  logic          writeEn;
  logic [2:0]    writeRegSel;
  logic [BW-1:0] writeData;
  logic [2:0]    lookup1RegSel;
  logic          lookup1Hit;
  logic [BW-1:0] lookup1Data;
  logic [2:0]    lookup2RegSel;
  logic          lookup2Hit;
  logic [BW-1:0] lookup2Data;
  logic          err;

  int compared   = 0;
  int mismatched = 0;
  int exp_count  = 0;
  logic exp_err  = 1'b0;
  logic mon_en   = 1'b0;
  logic [18:0] sb[$];

  wb_write_queue #(.BITWIDTH(BW), .DEPTH(DP)) dut (
    .clk(clk),
    .rst(rst),
    .memValid(memValid),
    .memRegSel(memRegSel),
    .memData(memData),
    .aluValid(aluValid),
    .aluRegSel(aluRegSel),
    .aluData(aluData),
    .stall(stall),
    .writeEn(writeEn),
    .writeRegSel(writeRegSel),
    .writeData(writeData),
    .lookup1RegSel(lookup1RegSel),
    .lookup1Hit(lookup1Hit),
    .lookup1Data(lookup1Data),
    .lookup2RegSel(lookup2RegSel),
    .lookup2Hit(lookup2Hit),
    .lookup2Data(lookup2Data),
    .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic exp_stall();
    return (DP - exp_count + ((exp_count != 0) ? 1 : 0)) < 2;
  endfunction

  // Drain monitor: every register-file write must match the oldest expected.
  always @(posedge clk) begin
    #1;
    if (mon_en && !rst && writeEn === 1'b1) begin
      compared++;
      if (sb.size() == 0) begin
        mismatched++;
        $display("FAIL drain_unexpected: got r%0d=%h, none expected",
                 writeRegSel, writeData);
      end else begin
        logic [18:0] e;
        e = sb.pop_front();
        if ({writeRegSel, writeData} !== e) begin
          mismatched++;
          $display("FAIL drain_order: got r%0d=%h, expected r%0d=%h",
                   writeRegSel, writeData, e[18:16], e[15:0]);
        end
      end
    end
  end

  // Called at negedge; drives one cycle and returns at the next negedge.
  task automatic cycle(input logic mv, input logic [2:0] mr,
                       input logic [BW-1:0] md, input logic av,
                       input logic [2:0] ar, input logic [BW-1:0] ad);
    logic st;
    int   n;
    st = exp_stall();
    memValid  = mv;
    memRegSel = mr;
    memData   = md;
    aluValid  = av;
    aluRegSel = ar;
    aluData   = ad;
    n = 0;
    if (!st) begin
      if (mv) begin sb.push_back({mr, md}); n++; end
      if (av) begin sb.push_back({ar, ad}); n++; end
    end else if (mv || av) begin
      exp_err = 1'b1;
    end
    @(posedge clk);
    exp_count = exp_count + n - ((exp_count != 0) ? 1 : 0);
    @(negedge clk);
    memValid = 1'b0;
    aluValid = 1'b0;
  endtask

  task automatic idle();
    cycle(1'b0, 3'd0, '0, 1'b0, 3'd0, '0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    memValid = 1'b1; memRegSel = 3'd1; memData = 16'h0101;
    aluValid = 1'b1; aluRegSel = 3'd2; aluData = 16'h0202;
    lookup1RegSel = 3'd1;
    lookup2RegSel = 3'd2;
    repeat (2) @(posedge clk);
    @(negedge clk);
    compared++;
    if (writeEn !== 1'b0 || stall !== 1'b0 || err !== 1'b0 ||
        lookup1Hit !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_state: we=%b stall=%b err=%b hit1=%b, need all 0",
               writeEn, stall, err, lookup1Hit);
    end
    rst = 1'b0;
    memValid = 1'b0;
    aluValid = 1'b0;
    exp_count = 0;
    exp_err = 1'b0;
    @(negedge clk);
    compared++;
    if (writeEn !== 1'b0 || lookup2Hit !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_empty: we=%b hit2=%b, need 0 0",
               writeEn, lookup2Hit);
    end
    mon_en = 1'b1;
  endtask

  task automatic test_single_write();
    lookup1RegSel = 3'd3;
    cycle(1'b0, 3'd0, '0, 1'b1, 3'd3, 16'h1234);
    compared++;
    if (writeEn !== 1'b1 || writeRegSel !== 3'd3 || writeData !== 16'h1234) begin
      mismatched++;
      $display("FAIL single_latency: we=%b r%0d=%h, need 1 r3=1234",
               writeEn, writeRegSel, writeData);
    end
    compared++;
    if (lookup1Hit !== 1'b1 || lookup1Data !== 16'h1234) begin
      mismatched++;
      $display("FAIL single_bypass: hit=%b data=%h, need 1 1234",
               lookup1Hit, lookup1Data);
    end
    idle();
    compared++;
    if (writeEn !== 1'b0 || writeRegSel !== 3'd0 || writeData !== 16'h0) begin
      mismatched++;
      $display("FAIL single_idle: we=%b r%0d=%h, need 0 r0=0000",
               writeEn, writeRegSel, writeData);
    end
  endtask

  task automatic test_dual_order();
    lookup1RegSel = 3'd2;
    cycle(1'b1, 3'd2, 16'hAAAA, 1'b1, 3'd2, 16'h5555);
    compared++;
    if (writeRegSel !== 3'd2 || writeData !== 16'hAAAA) begin
      mismatched++;
      $display("FAIL dual_first: r%0d=%h, need r2=aaaa",
               writeRegSel, writeData);
    end
    compared++;
    if (lookup1Hit !== 1'b1 || lookup1Data !== 16'h5555) begin
      mismatched++;
      $display("FAIL dual_bypass_young: hit=%b data=%h, need 1 5555",
               lookup1Hit, lookup1Data);
    end
    idle();
    compared++;
    if (writeData !== 16'h5555 || lookup1Data !== 16'h5555) begin
      mismatched++;
      $display("FAIL dual_second: wd=%h lk=%h, need 5555 5555",
               writeData, lookup1Data);
    end
    idle();
    compared++;
    if (writeEn !== 1'b0 || lookup1Hit !== 1'b0) begin
      mismatched++;
      $display("FAIL dual_drained: we=%b hit=%b, need 0 0",
               writeEn, lookup1Hit);
    end
  endtask

  task automatic fill3(input logic [BW-1:0] tag);
    cycle(1'b1, 3'd1, tag | 16'h0011, 1'b1, 3'd2, tag | 16'h0022);
    compared++;
    if (stall !== 1'b0) begin
      mismatched++;
      $display("FAIL fill_count2_stall: stall=%b, need 0", stall);
    end
    cycle(1'b1, 3'd3, tag | 16'h0033, 1'b1, 3'd1, tag | 16'h0044);
    cycle(1'b1, 3'd5, tag | 16'h0055, 1'b1, 3'd6, tag | 16'h0066);
  endtask

  task automatic test_fill_stall();
    lookup1RegSel = 3'd1;
    lookup2RegSel = 3'd2;
    fill3(16'h1100);
    compared++;
    if (stall !== 1'b1 || err !== 1'b0) begin
      mismatched++;
      $display("FAIL fill_full: stall=%b err=%b, need 1 0", stall, err);
    end
    compared++;
    if (lookup1Hit !== 1'b1 || lookup1Data !== 16'h1144 ||
        lookup2Hit !== 1'b0) begin
      mismatched++;
      $display("FAIL fill_bypass: h1=%b d1=%h h2=%b, need 1 1144 0",
               lookup1Hit, lookup1Data, lookup2Hit);
    end
    repeat (5) idle();
    compared++;
    if (writeEn !== 1'b0 || err !== 1'b0 || sb.size() != 0) begin
      mismatched++;
      $display("FAIL fill_drain: we=%b err=%b left=%0d, need 0 0 0",
               writeEn, err, sb.size());
    end
  endtask

  task automatic test_overflow();
    lookup2RegSel = 3'd7;
    fill3(16'h2200);
    cycle(1'b1, 3'd7, 16'hBEEF, 1'b0, 3'd0, '0);
    compared++;
    if (err !== 1'b1 || lookup2Hit !== 1'b0) begin
      mismatched++;
      $display("FAIL overflow_drop: err=%b hit2=%b, need 1 0",
               err, lookup2Hit);
    end
    for (int i = 0; i < 5; i++) begin
      compared++;
      if (writeEn === 1'b1 && writeRegSel === 3'd7) begin
        mismatched++;
        $display("FAIL overflow_r7_written: r7=%h", writeData);
      end
      idle();
    end
    compared++;
    if (err !== 1'b1 || writeEn !== 1'b0) begin
      mismatched++;
      $display("FAIL overflow_sticky: err=%b we=%b, need 1 0", err, writeEn);
    end
  endtask

  task automatic test_wrap_reset();
    for (int i = 0; i < 16; i++) begin
      compared++;
      if (stall !== exp_stall()) begin
        mismatched++;
        $display("FAIL wrap_stall: stall=%b need %b at step %0d",
                 stall, exp_stall(), i);
      end
      if (!exp_stall())
        cycle(1'b1, 3'(i), 16'($urandom),
              1'b1, 3'(i + 3), 16'($urandom));
      else
        idle();
    end
    repeat (6) idle();
    compared++;
    if (sb.size() != 0 || writeEn !== 1'b0) begin
      mismatched++;
      $display("FAIL wrap_drain: left=%0d we=%b, need 0 0",
               sb.size(), writeEn);
    end
    cycle(1'b1, 3'd4, 16'hC0DE, 1'b1, 3'd5, 16'hCAFE);
    cycle(1'b1, 3'd6, 16'hD00D, 1'b1, 3'd0, 16'hF00D);
    rst = 1'b1;
    sb.delete();
    exp_count = 0;
    exp_err = 1'b0;
    @(negedge clk);
    compared++;
    if (writeEn !== 1'b0 || err !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_mid_drain: we=%b err=%b, need 0 0", writeEn, err);
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idle();
      compared++;
      if (writeEn !== 1'b0) begin
        mismatched++;
        $display("FAIL reset_discard: r%0d=%h appeared after reset",
                 writeRegSel, writeData);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    memValid = 1'b0; memRegSel = '0; memData = '0;
    aluValid = 1'b0; aluRegSel = '0; aluData = '0;
    lookup1RegSel = '0;
    lookup2RegSel = '0;
    @(negedge clk);
    test_reset();
    test_single_write();
    test_dual_order();
    test_fill_stall();
    test_overflow();
    test_wrap_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
